beeper_dac_feeder: RTL and testbench

Converts the machine's 1-bit beeper and tape-out signals into 16-bit signed PCM samples at the codec sample rate. Each sample is a box-filter average over one sample period. It drives the audio core's to_dac left/right Avalon-ST sink channels with valid/ready, the same sample on both channels. It sits between the CPU/ULA port logic and the audio_io core.

---
 rtl/audio_pkg.sv | 30 +++
 rtl/beeper_dac_feeder_if.sv | 12 +
 rtl/audio_st_hold.sv | 34 +++
 rtl/beeper_dac_feeder.sv | 170 +++++++++++++++++
 tb/tb_beeper_dac_feeder.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the beeper/tape-to-PCM audio path.
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    localparam int RECIP_SHIFT   = 24;
    localparam int BEEPER_WEIGHT = 3;
    localparam int TAPE_WEIGHT   = 1;
    localparam int OVR_W         = 8;

    // Fixed-point reciprocal that maps a full-period accumulator (0..4N) onto 0..2*AMP.
    function automatic longint unsigned calc_recip(
        input longint unsigned clk_hz,
        input longint unsigned sample_hz,
        input longint unsigned amp
    );
        longint unsigned n;
        longint unsigned den;
        longint unsigned num;
        n   = clk_hz / sample_hz;
        den = 64'd4 * n;
        num = (64'd1 << RECIP_SHIFT) * 64'd2 * amp;
        return (num + den / 64'd2) / den;
    endfunction

    function automatic logic signed [17:0] sext18(input sample_t v);
        return {{2{v[15]}}, v};
    endfunction

endpackage

// File: rtl/beeper_dac_feeder_if.sv
// Avalon-ST sample channel: data/valid from source, ready from sink.
interface beeper_dac_feeder_if;
    import audio_pkg::*;

    sample_t data;
    logic    valid;
    logic    ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/audio_st_hold.sv
// One-entry Avalon-ST holding register; a load onto an unaccepted entry is an overrun.
module audio_st_hold
    import audio_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  sample_t               data_i,
    beeper_dac_feeder_if.master   st,
    output logic                  overrun_o
);

    sample_t data_q;
    logic    valid_q;

    assign overrun_o = load_i && valid_q && !st.ready;

    // A load wins over an accept: the old entry is either taken this edge or dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (valid_q && st.ready) begin
            valid_q <= 1'b0;
        end
    end

    assign st.data  = data_q;
    assign st.valid = valid_q;

endmodule

// File: rtl/beeper_dac_feeder.sv
// Box-filters beeper/tape levels over one sample period into signed PCM for both DAC channels.
// Optional high-pass DC blocker enabled by defining BEEPER_DAC_DC_BLOCK_EN.
module beeper_dac_feeder
    import audio_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int SAMPLE_HZ = 48000,
    parameter int AMP       = 8192
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              beeper_i,
    input  logic              tape_i,
    input  logic              mute_i,
    output logic [15:0]       to_dac_left_data,
    output logic              to_dac_left_valid,
    input  logic              to_dac_left_ready,
    output logic [15:0]       to_dac_right_data,
    output logic              to_dac_right_valid,
    input  logic              to_dac_right_ready,
    output logic [OVR_W-1:0]  overrun_count
);

    localparam int N      = CLK_HZ / SAMPLE_HZ;
    localparam int ACC_W  = $clog2(4 * N + 1);
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int PROD_W = ACC_W + 64;
    localparam longint unsigned RECIP = calc_recip(64'(CLK_HZ), 64'(SAMPLE_HZ), 64'(AMP));

    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_final;
    logic [ACC_W-1:0] s1_q;
    logic             s1_mute_q;
    logic             s1_vld_q;
    logic [2:0]       contrib;
    logic             tick;

    assign tick      = (cnt_q == CNT_W'(N - 1));
    assign contrib   = (beeper_i ? 3'(BEEPER_WEIGHT) : 3'd0) + (tape_i ? 3'(TAPE_WEIGHT) : 3'd0);
    assign acc_final = acc_q + ACC_W'(contrib);

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            s1_q      <= '0;
            s1_mute_q <= 1'b0;
            s1_vld_q  <= 1'b0;
        end else begin
            s1_vld_q <= tick;
            if (tick) begin
                cnt_q     <= '0;
                acc_q     <= '0;
                s1_q      <= acc_final;
                s1_mute_q <= mute_i;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
                acc_q <= acc_final;
            end
        end
    end

    logic [PROD_W-1:0]  prod;
    logic [31:0]        scaled;
    logic signed [31:0] diff;
    sample_t            s2_raw;
    sample_t            s2_sample;

    assign prod = PROD_W'(s1_q) * PROD_W'(RECIP);

    // Scaled value spans 0..2*AMP; recentre around zero and clamp the rounding excursion.
    always_comb begin
        scaled = 32'(prod >> RECIP_SHIFT);
        diff   = $signed(scaled) - AMP;
        if (diff > AMP)       s2_raw = sample_t'(AMP);
        else if (diff < -AMP) s2_raw = sample_t'(-AMP);
        else                  s2_raw = sample_t'(diff);
        s2_sample = s1_mute_q ? '0 : s2_raw;
    end

    logic    load;
    sample_t load_data;

`ifdef BEEPER_DAC_DC_BLOCK_EN
    sample_t            x_prev_q;
    sample_t            y_prev_q;
    sample_t            y_q;
    logic               y_vld_q;
    logic signed [17:0] y_full;
    sample_t            y_sat;

    always_comb begin
        y_full = sext18(s2_sample) - sext18(x_prev_q) + sext18(y_prev_q) - sext18(y_prev_q >>> 8);
        if (y_full > 18'sd32767)       y_sat = 16'sh7FFF;
        else if (y_full < -18'sd32768) y_sat = 16'sh8000;
        else                           y_sat = y_full[15:0];
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            x_prev_q <= '0;
            y_prev_q <= '0;
            y_q      <= '0;
            y_vld_q  <= 1'b0;
        end else begin
            y_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                x_prev_q <= s2_sample;
                y_prev_q <= y_sat;
                y_q      <= y_sat;
            end
        end
    end

    assign load      = y_vld_q;
    assign load_data = y_q;
`else
    assign load      = s1_vld_q;
    assign load_data = s2_sample;
`endif

    beeper_dac_feeder_if left_st ();
    beeper_dac_feeder_if right_st ();

    logic ovr_l;
    logic ovr_r;

    audio_st_hold u_hold_left (
        .clk_i     (clk_clk),
        .rst_ni    (reset_reset_n),
        .load_i    (load),
        .data_i    (load_data),
        .st        (left_st),
        .overrun_o (ovr_l)
    );

    audio_st_hold u_hold_right (
        .clk_i     (clk_clk),
        .rst_ni    (reset_reset_n),
        .load_i    (load),
        .data_i    (load_data),
        .st        (right_st),
        .overrun_o (ovr_r)
    );

    assign left_st.ready      = to_dac_left_ready;
    assign right_st.ready     = to_dac_right_ready;
    assign to_dac_left_data   = left_st.data;
    assign to_dac_left_valid  = left_st.valid;
    assign to_dac_right_data  = right_st.data;
    assign to_dac_right_valid = right_st.valid;

    logic [OVR_W-1:0] ovr_q;
    logic [OVR_W-1:0] ovr_d;

    // Simultaneous overruns on both channels are one dropped sample.
    always_comb begin
        ovr_d = ovr_q;
        if ((ovr_l || ovr_r) && (ovr_q != {OVR_W{1'b1}})) ovr_d = ovr_q + OVR_W'(1);
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) ovr_q <= '0;
        else                ovr_q <= ovr_d;
    end

    assign overrun_count = ovr_q;

endmodule

// File: tb/tb_beeper_dac_feeder.sv
// Directed bench for beeper_dac_feeder with N=10, AMP=8192.
module tb_beeper_dac_feeder;
    import audio_pkg::*;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       beeper = 1'b0;
    logic       tape   = 1'b0;
    logic       mute   = 1'b0;
    logic [7:0] ovr;

    beeper_dac_feeder_if left_if ();
    beeper_dac_feeder_if right_if ();

    always #5 clk = ~clk;

    beeper_dac_feeder #(.CLK_HZ(1000), .SAMPLE_HZ(100), .AMP(8192)) dut (
        .clk_clk            (clk),
        .reset_reset_n      (rst_n),
        .beeper_i           (beeper),
        .tape_i             (tape),
        .mute_i             (mute),
        .to_dac_left_data   (left_if.data),
        .to_dac_left_valid  (left_if.valid),
        .to_dac_left_ready  (left_if.ready),
        .to_dac_right_data  (right_if.data),
        .to_dac_right_valid (right_if.valid),
        .to_dac_right_ready (right_if.ready),
        .overrun_count      (ovr)
    );

`ifdef BEEPER_DAC_DC_BLOCK_EN
    localparam int CAP_PH = 2;
`else
    localparam int CAP_PH = 1;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int ph      = 0;
    int cap_l, cap_r, cap_vl, cap_vr, cap_vr2, cap_nv;

    task automatic check_val(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Advance one clock; ph mirrors the expected period counter.
    task automatic step();
        logic was_rst;
        was_rst = !rst_n;
        @(posedge clk);
        #1;
        ph = was_rst ? 0 : (ph + 1) % 10;
    endtask

    // Drive one full period from ph==0 and capture the previous period's sample.
    task automatic run_period(input logic [9:0] bm, input logic [9:0] tm, input logic [9:0] rr);
        cap_nv = 0;
        for (int k = 0; k < 10; k++) begin
            beeper         = bm[k];
            tape           = tm[k];
            right_if.ready = rr[k];
            if (left_if.valid) cap_nv++;
            if (k == CAP_PH) begin
                cap_l  = int'(sample_t'(left_if.data));
                cap_r  = int'(sample_t'(right_if.data));
                cap_vl = int'(left_if.valid);
                cap_vr = int'(right_if.valid);
            end
            if (k == CAP_PH + 1) cap_vr2 = int'(right_if.valid);
            step();
        end
    endtask

    localparam logic [9:0] ALL = 10'h3FF;
    localparam logic [9:0] NON = 10'h000;

    logic [9:0] pat_b [7] = '{ALL, NON, ALL, NON, 10'b0000011111, ALL, ALL};
    logic [9:0] pat_t [7] = '{NON, NON, ALL, ALL, NON, NON, NON};
    int         pat_e [7] = '{4096, -8192, 8192, -4096, -2048, 0, 4096};

    initial begin
        left_if.ready  = 1'b1;
        right_if.ready = 1'b1;
        rst_n = 1'b0;
        step(); step(); step();
        check_val("rst_data_l", int'(sample_t'(left_if.data)), 0);
        check_val("rst_valid_l", int'(left_if.valid), 0);
        check_val("rst_valid_r", int'(right_if.valid), 0);
        check_val("rst_ovr", int'(ovr), 0);
        rst_n = 1'b1;

`ifdef BEEPER_DAC_DC_BLOCK_EN
        run_period(ALL, NON, ALL);
        check_val("dc_first_period_nv", cap_nv, 0);
        run_period(ALL, NON, ALL);
        check_val("dc_s0_l", cap_l, 4096);
        check_val("dc_s0_r", cap_r, 4096);
        check_val("dc_s0_v", cap_vl, 1);
        check_val("dc_s0_nv", cap_nv, 1);
        run_period(ALL, NON, ALL);
        check_val("dc_s1_l", cap_l, 4080);
        check_val("dc_s1_r", cap_r, 4080);
        run_period(ALL, NON, ALL);
        check_val("dc_s2_l", cap_l, 4065);
        check_val("dc_s2_nv", cap_nv, 1);
`else
        for (int i = 0; i < 7; i++) begin
            mute = (i == 5);
            run_period(pat_b[i], pat_t[i], ALL);
            if (i == 0) begin
                check_val("first_period_nv", cap_nv, 0);
            end else begin
                check_val($sformatf("pat%0d_l", i - 1), cap_l, pat_e[i - 1]);
                check_val($sformatf("pat%0d_r", i - 1), cap_r, pat_e[i - 1]);
                check_val($sformatf("pat%0d_vl", i - 1), cap_vl, 1);
                check_val($sformatf("pat%0d_vr", i - 1), cap_vr, 1);
                check_val($sformatf("pat%0d_nv", i - 1), cap_nv, 1);
            end
        end
        mute = 1'b0;

        // Right sink stalls for 25 cycles starting on a valid cycle.
        run_period(ALL, NON, ALL);
        check_val("pat6_l", cap_l, 4096);
        run_period(NON, NON, 10'b0000000001);
        check_val("ovr_o1_r", cap_r, 4096);
        check_val("ovr_o1_vr", cap_vr, 1);
        run_period(ALL, ALL, NON);
        check_val("ovr_o2_r", cap_r, -8192);
        check_val("ovr_o2_vr2", cap_vr2, 1);
        check_val("ovr_o2_l", cap_l, -8192);
        check_val("ovr_o2_nv", cap_nv, 1);
        check_val("ovr_o2_cnt", int'(ovr), 1);
        run_period(NON, NON, 10'b1111000000);
        check_val("ovr_o3_r", cap_r, 8192);
        check_val("ovr_o3_cnt", int'(ovr), 2);
        check_val("ovr_o3_vr_after", int'(right_if.valid), 0);

        // Accept and load on the same edge must not count as an overrun.
        run_period(ALL, NON, 10'b0000000001);
        check_val("acc_o4_r", cap_r, -8192);
        run_period(NON, ALL, ALL);
        check_val("acc_o5_r", cap_r, 4096);
        check_val("acc_o5_vr", cap_vr, 1);
        check_val("acc_o5_cnt", int'(ovr), 2);

        for (int i = 0; i < 260; i++) run_period(ALL, NON, NON);
        check_val("ovr_sat_cnt", int'(ovr), 255);
        check_val("ovr_sat_vr", int'(right_if.valid), 1);
        check_val("ovr_sat_r", int'(sample_t'(right_if.data)), 4096);
        check_val("ovr_sat_l", cap_l, 4096);

        // Reset in the cycle where the counter reads 5, with a partial period accumulated.
        right_if.ready = 1'b1;
        beeper = 1'b1;
        for (int k = 0; k < 5; k++) step();
        rst_n = 1'b0;
        step();
        check_val("mid_rst_data_l", int'(sample_t'(left_if.data)), 0);
        check_val("mid_rst_data_r", int'(sample_t'(right_if.data)), 0);
        check_val("mid_rst_valid_r", int'(right_if.valid), 0);
        check_val("mid_rst_ovr", int'(ovr), 0);
        rst_n = 1'b1;
        run_period(NON, NON, ALL);
        check_val("mid_rst_nv", cap_nv, 0);
        run_period(ALL, NON, ALL);
        check_val("mid_rst_s0_l", cap_l, -8192);
        check_val("mid_rst_s0_vl", cap_vl, 1);
        run_period(NON, NON, ALL);
        check_val("mid_rst_s1_l", cap_l, 4096);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time exceeded, got timeout, expected finish");
        $fatal(1);
    end

endmodule
